// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator with lock sequencing.
// Each channel runs its own 0..div counter once the shared lock sequence has
// completed. It emits a one-cycle ce pulse at the (clamped) phase slot and a
// square wave that toggles on every pulse. Any accepted configuration write
// restarts the lock sequence, so all channels re-align to a common origin.
module clk_enable_gen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] div_clk,
    output logic              locked
);

    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    typedef enum logic {
        LOCKING = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    state_t         state;
    logic [LCW-1:0] lock_cnt;
    logic           primed;
    logic           cfg_hit;

    // A phase beyond the period lands on the last slot of the period.
    function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] p,
                                                     input logic [CNT_W-1:0] d);
        return (p > d) ? d : p;
    endfunction

    // Writes to channels that do not exist are ignored entirely.
    assign cfg_hit = cfg_we && (32'(cfg_ch) < 32'(NUM_CH));

    // Lock sequencer: the first edge after reset and every accepted write restart the count.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state    <= LOCKING;
            lock_cnt <= '0;
            primed   <= 1'b0;
            locked   <= 1'b0;
        end else begin
            primed <= 1'b1;
            locked <= (state == LOCKED);
            if (cfg_hit || !primed) begin
                state    <= LOCKING;
                lock_cnt <= '0;
            end else if (state == LOCKING) begin
                if (lock_cnt == LOCK_LAST) begin
                    state <= LOCKED;
                end else begin
                    lock_cnt <= lock_cnt + LCW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] phase_q;
        logic             en_q;
        logic [CNT_W-1:0] cnt_q;
        logic             ce_q;
        logic             dclk_q;
        logic             hit;

        assign hit        = (state == LOCKED) && en_q &&
                            (cnt_q == clamp_phase(phase_q, div_q));
        assign ce[i]      = ce_q;
        assign div_clk[i] = dclk_q;

        // Per-channel configuration registers.
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                div_q   <= '0;
                phase_q <= '0;
                en_q    <= 1'b1;
            end else if (cfg_hit && (cfg_ch == CH_W'(i))) begin
                div_q   <= cfg_div;
                phase_q <= cfg_phase;
                en_q    <= cfg_en;
            end
        end

        // Period counter: held at 0 while locking, wraps after div when locked.
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (state != LOCKED) begin
                cnt_q <= '0;
            end else if (cnt_q == div_q) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        // Registered pulse and square wave; the wave restarts low after every relock.
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                ce_q   <= 1'b0;
                dclk_q <= 1'b0;
            end else begin
                ce_q <= hit;
                if ((state != LOCKED) || !en_q) begin
                    dclk_q <= 1'b0;
                end else if (hit) begin
                    dclk_q <= ~dclk_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: expected outputs come from a
// cycle-indexed model (lock edge, phase offset, period) pushed to a queue
// before each edge and compared just after it.
module tb_clk_enable_gen;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int LC     = 16;
    localparam int CH_W   = 2;

    logic              refclk = 1'b0;
    logic              rst    = 1'b1;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [CNT_W-1:0]  cfg_phase = '0;
    logic              cfg_en = 1'b1;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] div_clk;
    logic              locked;

    int checks = 0;
    int errors = 0;

    clk_enable_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYCLES(LC), .CH_W(CH_W)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_en(cfg_en),
        .ce(ce), .div_clk(div_clk), .locked(locked)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [NUM_CH-1:0] ce;
        logic [NUM_CH-1:0] dclk;
        logic              lk;
    } exp_t;

    exp_t sb[$];

    int edge_n;
    int lk_edge;
    int m_div [NUM_CH];
    int m_ph  [NUM_CH];
    bit m_en  [NUM_CH];

    function automatic exp_t predict(input int e);
        exp_t x;
        x = '0;
        x.lk = (e >= lk_edge);
        for (int c = 0; c < NUM_CH; c++) begin
            int pe;
            int k;
            pe = (m_ph[c] > m_div[c]) ? m_div[c] : m_ph[c];
            k  = e - lk_edge - pe;
            if (x.lk && m_en[c] && k >= 0) begin
                x.ce[c]   = ((k % (m_div[c] + 1)) == 0);
                x.dclk[c] = (((k / (m_div[c] + 1)) % 2) == 0);
            end
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp_v);
        end
    endtask

    task automatic model_defaults();
        for (int c = 0; c < NUM_CH; c++) begin
            m_div[c] = 0;
            m_ph[c]  = 0;
            m_en[c]  = 1'b1;
        end
    endtask

    // One clock edge: predict, clock, update model for an accepted write, compare.
    task automatic step();
        exp_t x;
        sb.push_back(predict(edge_n));
        @(posedge refclk);
        if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
            m_div[int'(cfg_ch)] = int'(cfg_div);
            m_ph[int'(cfg_ch)]  = int'(cfg_phase);
            m_en[int'(cfg_ch)]  = cfg_en;
            lk_edge = edge_n + LC + 1;
        end
        #1;
        x = sb.pop_front();
        check("ce", 32'(ce), 32'(x.ce));
        check("div_clk", 32'(div_clk), 32'(x.dclk));
        check("locked", 32'(locked), 32'(x.lk));
        edge_n++;
        cfg_we = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic write(input int ch, input int d, input int p, input bit en);
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(d);
        cfg_phase = CNT_W'(p);
        cfg_en    = en;
        cfg_we    = 1'b1;
        step();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        edge_n  = 0;
        lk_edge = LC + 1;
        model_defaults();
    endtask

    initial begin
        model_defaults();
        edge_n  = 0;
        lk_edge = LC + 1;

        // Reset held: outputs idle.
        repeat (2) @(posedge refclk);
        #1;
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_div_clk", 32'(div_clk), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        // Defaults: lock at edge 17, ce every cycle, div_clk at refclk/2.
        release_reset();
        steps(30);

        // ch0 D=3 P=2.
        write(0, 3, 2, 1'b1);
        steps(40);

        // ch1 D=4 P=9, phase clamps to 4.
        write(1, 4, 9, 1'b1);
        steps(40);

        // Second write 5 cycles into locking restarts the count (same values).
        write(0, 3, 2, 1'b1);
        steps(5);
        write(1, 4, 9, 1'b1);
        steps(30);

        // Out-of-range channel writes are ignored.
        write(3, 0, 0, 1'b0);
        steps(6);
        write(2, 1, 1, 1'b0);
        steps(10);

        // Disable ch0; ch1 keeps its configuration.
        write(0, 3, 2, 1'b0);
        steps(40);

        // Asynchronous reset mid-cycle while running.
        #2;
        rst = 1'b1;
        #1;
        check("async_ce", 32'(ce), 32'd0);
        check("async_div_clk", 32'(div_clk), 32'd0);
        check("async_locked", 32'(locked), 32'd0);
        @(posedge refclk);
        #1;
        check("hold_locked", 32'(locked), 32'd0);
        release_reset();
        steps(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Parametrised multi-channel clock-enable generator with lock sequencing, the synthesizable successor to the fixed two-output vendor PLL wrapper. From a single reference clock it produces NUM_CH independently programmable clock-enable pulse trains and matching divided square-wave outputs, each with its own divide ratio, phase offset and enable. A single `locked` flag gates downstream logic. Any run-time reconfiguration drops `locked`, re-aligns all channels and re-locks.

## Interface
Parameters:
- NUM_CH, 2: number of output channels (1..16).
- CNT_W, 8: width of the divide and phase fields. Channel period is cfg_div+1 cycles.
- LOCK_CYCLES, 16: cycles spent in LOCKING before `locked` asserts (>=1).
- CH_W, max(1, clog2(NUM_CH)): width of the channel select.

Ports:
- refclk  in  1  only clock; all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cfg_we  in  1  configuration write strobe, one cycle per write.
- cfg_ch  in  CH_W  channel being written.
- cfg_div  in  CNT_W  divide value D.
- cfg_phase  in  CNT_W  phase offset P.
- cfg_en  in  1  channel enable.
- ce  out  NUM_CH  per-channel one-cycle clock-enable pulses, registered.
- div_clk  out  NUM_CH  per-channel square wave; toggles on each ce pulse, registered.
- locked  out  1  high while all channels run aligned, registered.

## Operation
- Per-channel config registers {div, phase, en}:
  - Reset values: div=0, phase=0, en=1.
  - A write with cfg_we=1 and cfg_ch<NUM_CH updates the registers at that edge.
  - A write with cfg_ch>=NUM_CH is ignored entirely, with no state change.
- Effective phase Pe = min(phase, div). An out-of-range phase clamps to the last slot.
- State machine: LOCKING, LOCKED.
  - LOCKING: lock_cnt increments each cycle. When lock_cnt==LOCK_CYCLES-1 the next state is LOCKED. All channel counters are held at 0.
  - LOCKED: each channel counter cnt_i counts 0..div_i and wraps to 0.
  - A valid cfg write in any state forces LOCKING with lock_cnt=0 at that edge. This applies even if the written value is unchanged or the channel is disabled.
  - A write during LOCKING restarts the lock count.
- Outputs:
  - locked = registered (state==LOCKED).
  - ce_i = registered (state==LOCKED && en_i && cnt_i==Pe_i).
  - div_clk_i toggles in the same cycle ce_i is high.
  - div_clk_i is forced to 0 when en_i=0 or while LOCKING, so it restarts from 0 after every relock.
- div=0 gives a ce pulse every cycle once locked, and div_clk at refclk/2.
- All channels share lock timing, so channels with equal div and phase are cycle-identical.

## Timing
- Reset values: ce=0, div_clk=0, locked=0, state=LOCKING, lock_cnt=0, counters 0.
- Reset is asynchronous. Asserting rst mid-operation clears all outputs and config immediately, with no clock needed.
- Rising-edge numbering: the first edge after rst deasserts is edge 0.
  - lock_cnt reaches LOCK_CYCLES-1 at edge LOCK_CYCLES-1.
  - State becomes LOCKED at edge LOCK_CYCLES.
  - locked goes high at edge LOCK_CYCLES+1. Call this cycle L.
- cnt_i is 0 in cycle L-1, the first LOCKED cycle.
- The first ce_i pulse is in cycle L+Pe_i. Later pulses follow every div_i+1 cycles.
- After a valid write at edge W:
  - locked drops at edge W+1.
  - ce and div_clk are 0 from edge W+1.
  - locked rises again at edge W+LOCK_CYCLES+1.
- Simultaneous rst and cfg_we: reset wins.
- Latency from cfg_we to the new config taking effect on outputs is exactly one full relock.

## Test plan
- Reset release, defaults, LOCK_CYCLES=16 -> locked high at edge 17. ce[1:0]=2'b11 every cycle from cycle 17. div_clk toggles each cycle.
- Write ch0 D=3 P=2, relock -> ce[0] high at L+2, L+6, L+10. div_clk[0] period 8 cycles, starting low.
- Write ch1 D=4 P=9 -> phase clamps to 4. ce[1] at L+4, L+9, L+14.
- Second write 5 cycles into LOCKING -> locked delayed to 16 cycles after the second write's edge plus 1. A write with cfg_ch=3 when NUM_CH=2 -> locked stays high and outputs are unaffected.
- Write ch0 en=0 -> after relock, ce[0]=0 and div_clk[0]=0 permanently. ch1 still pulses per its config.
- Assert rst asynchronously between edges while locked and ce toggling -> all outputs 0 immediately. Config returns to defaults. Relock timing is as in the first case.
